// File: rtl/u_arr_mul8.sv
`default_nettype none
// ============================================================================
// Module      : u_arr_mul8
// Description : Unsigned 8x8 array multiplier with a registered 16-bit product.
//               The product is formed by an AND-gate partial-product matrix
//               reduced row by row with ripple-carry adder rows; the final
//               row supplies the upper product byte. One register stage
//               drives the output.
// Ports       : clk   - system clock, rising edge active
//               rst_n - asynchronous reset, active-low (clears out)
//               a     - 8-bit unsigned multiplicand
//               b     - 8-bit unsigned multiplier
//               out   - 16-bit unsigned product a*b, valid one clock later
// Revision    : 1.0 - initial release
// ============================================================================
module u_arr_mul8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] out
);

    // Partial-product matrix: w_pp[i][j] = a[j] & b[i]
    logic [7:0]  w_pp  [8];
    // Running sum of each row. Bit 0 is retired as a product bit, bits 8:1
    // feed the next row, and bit 8 holds the row's carry-out.
    logic [8:0]  w_sum [8];
    // Ripple carry chain inside rows 1..7 (bit 0 is the row's carry-in)
    logic [8:0]  w_c   [1:7];
    logic [15:0] w_prod;
    logic [15:0] r_out;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_pp_row
            assign w_pp[i] = a & {8{b[i]}};
        end
    endgenerate

    // Row 0 is just the first partial-product row; it has no carry-out.
    assign w_sum[0] = {1'b0, w_pp[0]};

    generate
        for (genvar i = 1; i < 8; i++) begin : g_add_row
            // Bit 0 of every row has no incoming carry, so it acts as a
            // half adder; the remaining positions are full adders.
            assign w_c[i][0] = 1'b0;
            for (genvar j = 0; j < 8; j++) begin : g_cell
                // Previous row shifted down by one plus this row's pp bit.
                // Position 7 picks up the previous row's carry-out (bit 8).
                assign w_sum[i][j]  = w_sum[i-1][j+1] ^ w_pp[i][j] ^ w_c[i][j];
                assign w_c[i][j+1]  = (w_sum[i-1][j+1] & w_pp[i][j])
                                    | (w_sum[i-1][j+1] & w_c[i][j])
                                    | (w_pp[i][j]      & w_c[i][j]);
            end
            assign w_sum[i][8] = w_c[i][8];
        end
    endgenerate

    generate
        for (genvar i = 0; i < 8; i++) begin : g_low_bits
            assign w_prod[i] = w_sum[i][0];
        end
    endgenerate

    // The last row's upper sums and carry-out form the high byte.
    assign w_prod[15:8] = w_sum[7][8:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 16'h0000;
        end else begin
            r_out <= w_prod;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_u_arr_mul8.sv
`default_nettype none
// ============================================================================
// Module      : tb_u_arr_mul8
// Description : Self-checking bench for u_arr_mul8. Expected products are
//               queued when operands are driven and popped one clock later
//               when the registered product is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u_arr_mul8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] out;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q [$];

    u_arr_mul8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] xx;
        logic [15:0] yy;
        xx = {8'h00, x};
        yy = {8'h00, y};
        return xx * yy;
    endfunction

    // Drive operands and queue what the product must be one edge later.
    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        a = x;
        b = y;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a = 8'd138;
        b = 8'd22;
        #2;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: out=%h expected=%h", out, 16'h0000);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%h expected=%h", k, out, 16'h0000);
            end
            a = a + 8'd5;   // operands moving while held in reset
            b = b + 8'd7;
        end
        drive(8'd138, 8'd22, 16'd3036);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL reset_release: scoreboard empty, out=%h", out);
        end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (out !== e) begin
                errors++;
                $display("FAIL reset_release: out=%0d expected=%0d", out, e);
            end
        end
    endtask

    task automatic test_increment;
        logic [7:0] x;
        logic [7:0] y;
        logic [15:0] e;
        x = 8'd138;
        y = 8'd22;
        for (int k = 1; k <= 70; k++) begin
            x = x + 8'd2;
            y = y + 8'd3;
            drive(x, y, model_mul(x, y));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL increment step %0d a=%0d b=%0d: out=%0d expected=%0d", k, x, y, out, e);
            end
            // Anchor a couple of steps to literal values.
            if (k == 1 || k == 2 || k == 59) begin
                checks++;
                if (out !== (k == 1 ? 16'd3500 : (k == 2 ? 16'd3976 : 16'd0))) begin
                    errors++;
                    $display("FAIL increment_anchor step %0d: out=%0d", k, out);
                end
            end
        end
    endtask

    task automatic test_extremes;
        logic [7:0]  xs [7];
        logic [7:0]  ys [7];
        logic [15:0] es [7];
        logic [15:0] e;
        xs = '{8'd255, 8'd255, 8'd1,   8'd128, 8'd0,   8'd128, 8'd77};
        ys = '{8'd255, 8'd1,   8'd255, 8'd128, 8'd200, 8'd2,   8'd0};
        es = '{16'd65025, 16'd255, 16'd255, 16'd16384, 16'd0, 16'd256, 16'd0};
        for (int k = 0; k < 7; k++) begin
            drive(xs[k], ys[k], es[k]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL extreme a=%0d b=%0d: out=%0d expected=%0d", xs[k], ys[k], out, e);
            end
        end
    endtask

    task automatic test_hold;
        logic [15:0] e;
        drive(8'd13, 8'd11, 16'd143);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        // Operands change between edges; out must not follow them.
        a = 8'd250;
        b = 8'd250;
        #3;
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL hold_between_edges: out=%0d expected=%0d", out, e);
        end
        exp_q.push_back(model_mul(8'd250, 8'd250));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL hold_next_edge: out=%0d expected=%0d", out, e);
        end
    endtask

    task automatic test_reset_midstream;
        logic [15:0] e;
        drive(8'd200, 8'd100, 16'd20000);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL midreset_before: out=%0d expected=%0d", out, e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_async_clear: out=%0d expected=0", out);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_after_release: out=%0d expected=0", out);
        end
        exp_q.push_back(16'd20000);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (out !== e) begin
            errors++;
            $display("FAIL midreset_recapture: out=%0d expected=%0d", out, e);
        end
    endtask

    task automatic test_exhaustive;
        logic [15:0] e;
        logic [7:0]  x;
        logic [7:0]  y;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                x = i[7:0];
                y = j[7:0];
                drive(x, y, model_mul(x, y));
                @(posedge clk); #1;
                e = exp_q.pop_front();
                checks++;
                if (out !== e) begin
                    errors++;
                    $display("FAIL exhaustive a=%0d b=%0d: out=%0d expected=%0d", x, y, out, e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_extremes();
        test_hold();
        test_reset_midstream();
        test_exhaustive();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/u_arr_mul8.md
Name: u_arr_mul8

Overview:
- Unsigned 8x8-bit array multiplier producing a full 16-bit product.
- Datapath structure:
  - AND-gate partial-product matrix.
  - Rows of half/full adders with ripple carry between rows.
  - Final ripple row for the upper bits.
- One output register stage sits in front of the product.
- Used as a flat arithmetic leaf block inside larger datapaths.

Parameters:
- None. Operand width is fixed at 8 bits and product width at 16 bits.

Ports:
- clk    input   1   system clock; rising edge active
- rst_n  input   1   asynchronous reset, active-low
- a      input   8   unsigned multiplicand
- b      input   8   unsigned multiplier
- out    output  16  unsigned product a*b, registered

Behaviour:
- Partial products: pp[i][j] = a[j] & b[i], for i,j in 0..7.
- Array reduction:
  - Row 0 bit 0 gives out[0] directly (a[0]&b[0]).
  - For rows i = 1..7, each row adds pp[i][*] to the shifted sum and carry of the previous row.
  - The LSB of each row's sum gives product bit i.
  - Row 1 uses half adders where there is no incoming carry.
  - The MSB position of each row takes the previous row's carry-out.
  - The final row's sums and carry-out give bits 8..15.
- Result must equal the exact unsigned product, with no truncation or overflow. The maximum is 255*255 = 65025 (0xFE01).
- The combinational product is captured into the out register on every rising clk edge.
- Latency:
  - out is valid 1 clock after a/b are presented.
  - Throughput is 1 product per cycle.
  - There is no handshake and no enable.
- Reset:
  - rst_n low forces out = 16'h0000 immediately, with no dependence on clk.
  - out holds 0 while rst_n is low, even if a and b are changing.
  - The first edge after rst_n deasserts captures the a*b present at that edge.
- Reset asserted mid-operation:
  - The pending product is discarded and out goes to 0 asynchronously.
  - No stale value may appear after release.
- Operand changes between edges have no effect on out until the next rising edge. The output is glitch-free since it is registered.
- No X propagation: with known a and b, out is fully defined after the first post-reset edge.
- Boundary conditions:
  - a=0 or b=0 gives out=0.
  - a=1 gives out=b.
  - b=1 gives out=a.
  - Powers of two give a shift result (e.g. 128*2 = 256).

Test Plan:
- Reset: rst_n=0 with a=8'd138, b=8'd22 and clk toggling -> out=0 throughout; release rst_n, first edge -> out=3036 (0x0BDC).
- Incrementing sequence: start a=138, b=22, then a+=2 and b+=3 per step with a sampled each edge -> out tracks one cycle later:
  - 140*25 = 3500
  - 142*28 = 3976
  - a wraps at 8 bits (e.g. 254+2 = 0 -> out=0).
- Extremes:
  - a=255, b=255 -> 65025 (0xFE01).
  - a=255, b=1 -> 255.
  - a=1, b=255 -> 255.
  - a=128, b=128 -> 16384.
  - a=0, b=200 -> 0.
- Reset mid-stream: drive a=200, b=100 (out=20000), pulse rst_n low between edges -> out drops to 0 before the next edge; after release, next edge -> out=20000.
- Exhaustive: all 65536 (a,b) pairs, one per cycle -> out == a*b on the following cycle, zero mismatches.
